// File: rtl/timer_arbiter.sv
// timer_arbiter: one shared interval timer handed out round-robin.
// The winner owns the timer for dur cycles, then receives a one-cycle done pulse.
module timer_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_CNT_BITS = 8
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*NUM_CNT_BITS-1:0] dur,
  input  logic                            abort,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic [NUM_CNT_BITS-1:0]         count_out
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           ptr, ptr_nxt, win;
  logic                    found;
  logic [NUM_CNT_BITS-1:0] dur_reg, dur_nxt, cnt, cnt_nxt, win_dur;
  logic [NUM_REQ-1:0]      ptr_1hot;

  // Round-robin search starting just after the last winner, wrapping.
  always_comb begin
    int idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign win_dur = dur[int'(win)*NUM_CNT_BITS +: NUM_CNT_BITS];

  // Decode of the current owner; grant and done are both views of it.
  always_comb begin
    ptr_1hot = '0;
    for (int i = 0; i < NUM_REQ; i++) ptr_1hot[i] = (ptr == IW'(i));
  end

  // Next-state logic: selection, counting, abort and completion.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    dur_nxt   = dur_reg;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          ptr_nxt   = win;
          dur_nxt   = win_dur;
          cnt_nxt   = '0;
          // A zero-length interval skips ownership and reports completion directly.
          state_nxt = (win_dur != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // abort takes precedence over a coincident terminal count.
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == dur_reg - 1'b1) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register; reset leaves requester 0 first in line.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      ptr     <= IW'(NUM_REQ-1);
      dur_reg <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      dur_reg <= dur_nxt;
      cnt     <= cnt_nxt;
    end
  end

  assign grant     = (state == RUN)  ? ptr_1hot : '0;
  assign done      = (state == DONE) ? ptr_1hot : '0;
  assign busy      = (state != IDLE);
  assign count_out = cnt;

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed scenarios plus random traffic, all outputs
// compared each cycle against an interval-level reference model.
module tb_timer_arbiter;

  localparam int NR = 4;
  localparam int CB = 8;

  logic             clk, nrst, abort;
  logic [NR-1:0]    req, grant, done;
  logic [NR*CB-1:0] dur;
  logic             busy;
  logic [CB-1:0]    count_out;

  int n_chk, n_err;

  // Reference model: owner, grant cycles still to go, elapsed, pending done, last winner.
  int m_own, m_left, m_el, m_pend, m_last;

  timer_arbiter #(.NUM_REQ(NR), .NUM_CNT_BITS(CB)) dut (
    .clk(clk), .nrst(nrst), .req(req), .dur(dur), .abort(abort),
    .grant(grant), .done(done), .busy(busy), .count_out(count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NR*CB-1:0] mkdur(input int d0, input int d1, input int d2, input int d3);
    return {CB'(d3), CB'(d2), CB'(d1), CB'(d0)};
  endfunction

  task automatic m_reset();
    m_own = 0; m_left = 0; m_el = 0; m_pend = -1; m_last = NR-1;
  endtask

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic m_step(input logic [NR-1:0] r, input logic [NR*CB-1:0] d, input logic a);
    int idx, dv;
    if (m_pend >= 0) begin
      m_pend = -1;
    end else if (m_left > 0) begin
      if (a) begin
        m_left = 0; m_el = 0;
      end else begin
        m_left--; m_el++;
        if (m_left == 0) begin m_el = 0; m_pend = m_own; end
      end
    end else if (r != '0) begin
      idx = -1;
      for (int k = 1; k <= NR; k++)
        if (idx < 0 && r[(m_last + k) % NR]) idx = (m_last + k) % NR;
      m_last = idx;
      m_own  = idx;
      dv     = int'(d[idx*CB +: CB]);
      m_el   = 0;
      if (dv == 0) m_pend = idx;
      else         m_left = dv;
    end
  endtask

  task automatic check_outputs();
    logic [NR-1:0] eg, ed;
    eg = '0; ed = '0;
    if (m_left > 0) eg[m_own]  = 1'b1;
    if (m_pend >= 0) ed[m_pend] = 1'b1;
    chk("grant", grant, eg);
    chk("done", done, ed);
    chk("busy", busy, (m_left > 0) || (m_pend >= 0));
    chk("count", count_out, (m_left > 0) ? m_el : 0);
    chk("grant_1hot", $onehot0(grant), 1);
    chk("done_1hot", $onehot0(done), 1);
  endtask

  // One cycle: check at negedge, drive, then model the following rising edge.
  task automatic step(input logic [NR-1:0] r, input logic [NR*CB-1:0] d, input logic a);
    @(negedge clk);
    check_outputs();
    req = r; dur = d; abort = a;
    @(posedge clk);
    m_step(r, d, a);
  endtask

  function automatic int idx_of(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    int order[$];
    int hl, gap, ng;
    logic [NR-1:0] pg;
    logic a, hit;

    n_chk = 0; n_err = 0;
    nrst = 1'b0; req = '0; dur = '0; abort = 1'b0;
    m_reset();
    #3;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count_out, 0);
    @(negedge clk); nrst = 1'b1;

    // All requesting, dur 2: order 0,1,2,3,0, two-cycle grants, two-cycle gaps.
    pg = '0; hl = 0; gap = 0; ng = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b1111, mkdur(2, 2, 2, 2), 1'b0);
      #1;
      if (grant != '0) begin
        if (pg == '0) begin
          order.push_back(idx_of(grant));
          if (ng > 0) chk("rr_gap", gap, 2);
          ng++; hl = 0;
        end
        hl++;
      end else begin
        if (pg != '0) begin chk("rr_len", hl, 2); gap = 0; end
        gap++;
      end
      pg = grant;
    end
    chk("rr_ngrants", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++) chk("rr_order", order[i], i % NR);
    for (int i = 0; i < 6; i++) step('0, '0, 1'b0);

    // Single requester, dur 3: count 0,1,2 then done.
    step(4'b0001, mkdur(3, 0, 0, 0), 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("d3_grant", grant, 4'b0001);
      chk("d3_count", count_out, i);
      step('0, '0, 1'b0);
    end
    #1;
    chk("d3_done", done, 4'b0001);
    chk("d3_gdrop", grant, 0);
    step('0, '0, 1'b0);
    #1;
    chk("d3_idle", busy, 0);

    // Zero duration: no grant, done right after selection, busy one cycle.
    step(4'b0100, mkdur(5, 5, 0, 5), 1'b0);
    #1;
    chk("d0_done", done, 4'b0100);
    chk("d0_grant", grant, 0);
    chk("d0_busy", busy, 1);
    step('0, '0, 1'b0);
    #1;
    chk("d0_busy_end", busy, 0);
    chk("d0_done_end", done, 0);

    // Abort at count 4 of dur 10, then wrap from the aborted winner.
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      a = (m_left > 0) && (m_el == 4);
      step((i == 0) ? 4'b0010 : 4'b0000, mkdur(0, 10, 0, 0), a);
      if (a) hit = 1'b1;
    end
    if (!hit) chk("ab10_timeout", 0, 1);
    #1;
    chk("ab10_grant", grant, 0);
    chk("ab10_done", done, 0);
    chk("ab10_count", count_out, 0);
    step(4'b0011, mkdur(1, 1, 0, 0), 1'b0);
    #1;
    chk("ab10_wrap", grant, 4'b0001);
    for (int i = 0; i < 4; i++) step('0, '0, 1'b0);

    // Abort coincident with terminal count: abort wins.
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      a = (m_left > 0) && (m_el == 4);
      step((i == 0) ? 4'b0001 : 4'b0000, mkdur(5, 0, 0, 0), a);
      if (a) hit = 1'b1;
    end
    if (!hit) chk("ab5_timeout", 0, 1);
    #1;
    chk("ab5_done", done, 0);
    chk("ab5_busy", busy, 0);
    step('0, '0, 1'b0);
    #1;
    chk("ab5_nodone", done, 0);

    // Abort outside RUN is ignored: done still issued.
    step(4'b0001, mkdur(0, 0, 0, 0), 1'b1);
    #1;
    chk("abidle_done", done, 4'b0001);
    step('0, '0, 1'b1);

    // Reset mid-interval at count 3 of dur 8.
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(4'b0100, mkdur(0, 0, 8, 0), 1'b0);
      hit = (m_left > 0) && (m_el == 3);
    end
    if (!hit) chk("rst8_timeout", 0, 1);
    @(negedge clk);
    check_outputs();
    req = '0; nrst = 1'b0;
    #1;
    chk("rst8_grant", grant, 0);
    chk("rst8_done", done, 0);
    chk("rst8_busy", busy, 0);
    chk("rst8_count", count_out, 0);
    m_reset();
    @(negedge clk); nrst = 1'b1;
    step(4'b1001, mkdur(2, 0, 0, 2), 1'b0);
    #1;
    chk("rst8_prio", grant, 4'b0001);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step(NR'($urandom_range(0, 15)),
           mkdur($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6)),
           ($urandom_range(0, 7) == 0));
    for (int i = 0; i < 10; i++) step('0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the timer.
REQ-002 SHALL have parameter NUM_CNT_BITS, default 8, width of each duration and of the internal counter.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  NUM_REQ  level request per requester.
REQ-006 SHALL have port dur  input  NUM_REQ*NUM_CNT_BITS  packed durations, requester i at bits [i*NUM_CNT_BITS +: NUM_CNT_BITS].
REQ-007 SHALL have port abort  input  1  cancels the interval in progress.
REQ-008 SHALL have port grant  output  NUM_REQ  one-hot ownership of the timer, all-zero when unowned.
REQ-009 SHALL have port done  output  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port count_out  output  NUM_CNT_BITS  elapsed cycles of the current interval.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE with any req bit high SHALL select a winner round-robin, searching from index (ptr+1) mod NUM_REQ upward with wrap; ptr = last winner.
REQ-014 On the selecting edge SHALL latch winner index into ptr and its dur slice into dur_reg; later dur changes ignored until next selection.
REQ-015 Selection with dur_reg value nonzero SHALL enter RUN with count_out=0 and grant=onehot(winner) registered on that edge.
REQ-016 Selection with dur value 0 SHALL go directly to DONE; grant never asserts for that interval.
REQ-017 In RUN count_out SHALL increment by 1 each cycle; when count_out == dur_reg-1 the next edge SHALL enter DONE, clear count_out to 0, drop grant.
REQ-018 grant SHALL therefore be high for exactly dur_reg cycles per non-aborted interval.
REQ-019 In DONE done[ptr] SHALL be high for exactly one cycle, grant all-zero; next edge SHALL return to IDLE.
REQ-020 Minimum gap between consecutive grants SHALL be 2 cycles (DONE, IDLE).
REQ-021 Deasserting req during RUN SHALL NOT shorten or cancel the interval.
REQ-022 abort high in RUN SHALL on next edge go to IDLE, clear count_out, drop grant, with no done pulse; ptr keeps the aborted winner.
REQ-023 abort and terminal count in the same cycle: abort SHALL win (no done).
REQ-024 abort in IDLE or DONE SHALL be ignored; DONE pulse still issued.
REQ-025 count_out SHALL never exceed dur_reg-1 and SHALL never wrap (dur_reg ≤ 2^NUM_CNT_BITS-1).
REQ-026 grant SHALL be one-hot or zero in every cycle; done SHALL be one-hot or zero.

Reset
REQ-027 nrst low SHALL immediately (asynchronously) force state=IDLE, grant=0, done=0, busy=0, count_out=0, dur_reg=0, ptr=NUM_REQ-1 (requester 0 highest priority first).
REQ-028 Reset asserted mid-RUN SHALL abandon the interval with no done pulse; after release the arbiter SHALL resume from IDLE with priority from index 0.

Verification
REQ-029 After reset, req=4'b0001, dur0=3 -> grant=0001 for exactly 3 cycles, count_out 0,1,2, then done=0001 one cycle, busy low after.
REQ-030 req=4'b1111 held, all dur=2 -> grants in order 0,1,2,3,0, each 2 cycles, 2-cycle gap between grants.
REQ-031 req=4'b0100, dur2=0 -> no grant, done=0100 one cycle after selection edge, busy high for exactly 1 cycle.
REQ-032 req=4'b0010, dur1=10, abort pulsed when count_out=4 -> grant drops next edge, no done, count_out=0; next req=0011 selects requester 2-wrap order: requester 0 before 1? -> requester 0 wins (search starts at index 2, wraps to 0).
REQ-033 dur0=5 grant active, abort asserted in the cycle count_out=4 -> no done pulse, IDLE next edge.
REQ-034 nrst pulsed low at count_out=3 of dur=8 -> all outputs 0 immediately; after release req=4'b1000 and 4'b0001 together -> requester 0 granted.
